// File: rtl/addsub_server.sv
// Shared add/subtract responder: arbitrates NUM_REQ requesters onto one registered adder/subtractor.
// Define ADDSUB_SERVER_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module addsub_server #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         mode_i,
    input  logic [NUM_REQ*DATA_W-1:0]  a_i,
    input  logic [NUM_REQ*DATA_W-1:0]  b_i,
    output logic [NUM_REQ-1:0]         ready_o,
    output logic [DATA_W-1:0]          res_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_o,
    output logic                       busy_o,
    output logic [CNT_W-1:0]           ops_cnt_o
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [GW-1:0]       ptr_q;
    logic [GW-1:0]       winner;
    logic                found;
    logic [NUM_REQ-1:0]  winner_onehot;
    logic [DATA_W-1:0]   a_sel;
    logic [DATA_W-1:0]   b_sel;
    logic [DATA_W-1:0]   result;

    always_comb begin
        winner = '0;
        found  = 1'b0;
`ifdef ADDSUB_SERVER_RR_EN
        // Search starts just past the last served requester and wraps around.
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req_i[(int'(ptr_q) + i) % NUM_REQ]) begin
                winner = GW'((int'(ptr_q) + i) % NUM_REQ);
                found  = 1'b1;
            end
        end
`else
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i]) begin
                winner = GW'(i);
                found  = 1'b1;
            end
        end
`endif
    end

`ifndef ADDSUB_SERVER_RR_EN
    logic ptr_unused;
    assign ptr_unused = ^ptr_q;
`endif

    always_comb begin
        winner_onehot         = '0;
        winner_onehot[winner] = 1'b1;
    end

    assign a_sel  = a_i[int'(winner)*DATA_W +: DATA_W];
    assign b_sel  = b_i[int'(winner)*DATA_W +: DATA_W];
    assign result = mode_i[winner] ? (a_sel + b_sel) : (a_sel - b_sel);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands and mode are captured at the grant edge only; RESP just replays the stored result.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ready_o   <= '0;
            res_o     <= '0;
            grant_o   <= '0;
            ops_cnt_o <= '0;
            ptr_q     <= GW'(NUM_REQ - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        res_o   <= result;
                        grant_o <= winner;
                        ready_o <= winner_onehot;
                    end
                end
                RESP: begin
                    ready_o   <= '0;
                    ops_cnt_o <= ops_cnt_o + CNT_W'(1);
                    ptr_q     <= grant_o;
                end
                default: ready_o <= '0;
            endcase
        end
    end

    assign busy_o = (state_q == RESP);

endmodule

// File: tb/tb_addsub_server.sv
// Self-checking bench for addsub_server: directed protocol cases plus randomized traffic
// compared cycle by cycle against an arithmetic reference model of the server.
module tb_addsub_server;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 4;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [2:0]  req_i;
    logic [2:0]  mode_i;
    logic [23:0] a_i;
    logic [23:0] b_i;
    logic [2:0]  ready_o;
    logic [7:0]  res_o;
    logic [1:0]  grant_o;
    logic        busy_o;
    logic [3:0]  ops_cnt_o;

    int testCount = 0;
    int failCount = 0;

    // Reference model state
    logic [2:0] mReady;
    int         mRes;
    int         mGrant;
    int         mLast;
    int         mCnt;
    bit         mBusy;

    int         grantLog[$];

    addsub_server #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .mode_i    (mode_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .ready_o   (ready_o),
        .res_o     (res_o),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .ops_cnt_o (ops_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int pickWinner(input logic [2:0] req, input int last);
`ifdef ADDSUB_SERVER_RR_EN
        for (int off = 1; off <= NUM_REQ; off++)
            if (req[(last + off) % NUM_REQ]) return (last + off) % NUM_REQ;
`else
        for (int c = 0; c < NUM_REQ; c++)
            if (req[c]) return c;
`endif
        return -1;
    endfunction

    function automatic int opA(input int k);
        return int'(a_i[k*8 +: 8]);
    endfunction

    function automatic int opB(input int k);
        return int'(b_i[k*8 +: 8]);
    endfunction

    task automatic modelReset();
        mReady = '0;
        mRes   = 0;
        mGrant = 0;
        mLast  = NUM_REQ - 1;
        mCnt   = 0;
        mBusy  = 0;
    endtask

    // One server step: a pulse always lasts one cycle, then a new winner may be granted.
    task automatic modelStep();
        int k;
        if (mBusy) begin
            mReady = '0;
            mCnt   = (mCnt + 1) % 16;
            mLast  = mGrant;
            mBusy  = 0;
        end else begin
            k = pickWinner(req_i, mLast);
            if (k >= 0) begin
                mRes   = mode_i[k] ? (opA(k) + opB(k)) % 256 : (opA(k) - opB(k) + 256) % 256;
                mGrant = k;
                mReady = 3'(1 << k);
                mBusy  = 1;
                grantLog.push_back(k);
            end
        end
    endtask

    task automatic applyStimulus(input logic [2:0] req, input logic [2:0] mode,
                                 input logic [23:0] av, input logic [23:0] bv);
        req_i  = req;
        mode_i = mode;
        a_i    = av;
        b_i    = bv;
    endtask

    task automatic checkOutput(input string tag);
        testCount++;
        assert (ready_o === mReady) else begin
            failCount++;
            $error("[TB] FAIL %s ready_o: got %0b expected %0b", tag, ready_o, mReady);
        end
        testCount++;
        assert (res_o === 8'(mRes)) else begin
            failCount++;
            $error("[TB] FAIL %s res_o: got %0h expected %0h", tag, res_o, 8'(mRes));
        end
        testCount++;
        assert (grant_o === 2'(mGrant)) else begin
            failCount++;
            $error("[TB] FAIL %s grant_o: got %0d expected %0d", tag, grant_o, mGrant);
        end
        testCount++;
        assert (busy_o === mBusy) else begin
            failCount++;
            $error("[TB] FAIL %s busy_o: got %0b expected %0b", tag, busy_o, mBusy);
        end
        testCount++;
        assert (ops_cnt_o === 4'(mCnt)) else begin
            failCount++;
            $error("[TB] FAIL %s ops_cnt_o: got %0d expected %0d", tag, ops_cnt_o, mCnt);
        end
    endtask

    task automatic runCycle(input string tag);
        @(posedge clk_i);
        modelStep();
        @(negedge clk_i);
        checkOutput(tag);
    endtask

    task automatic checkValue(input string tag, input int got, input int expected);
        testCount++;
        assert (got === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, got, expected);
        end
    endtask

    initial begin
        int expOrder[3];

        rst_n = 1'b0;
        applyStimulus(3'b000, 3'b000, 24'h0, 24'h0);
        modelReset();
        repeat (2) @(negedge clk_i);
        checkOutput("reset");
        rst_n = 1'b1;

        // All three requesters held for six cycles
        grantLog.delete();
        applyStimulus(3'b111, 3'b111, {8'd3, 8'd2, 8'd1}, {8'd30, 8'd20, 8'd10});
        for (int i = 1; i <= 6; i++) begin
            runCycle("all_three");
            if (i % 2 == 1) checkValue("pulse_cycle_busy", int'(busy_o), 1);
        end
`ifdef ADDSUB_SERVER_RR_EN
        expOrder = '{0, 1, 2};
`else
        expOrder = '{0, 0, 0};
`endif
        checkValue("grant_count", grantLog.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < grantLog.size()) checkValue("grant_order", grantLog[i], expOrder[i]);

        applyStimulus(3'b000, 3'b000, 24'h0, 24'h0);
        runCycle("drain");

        // Single request on requester 1
        applyStimulus(3'b010, 3'b010, {8'd0, 8'd20, 8'd0}, {8'd0, 8'd7, 8'd0});
        runCycle("single_grant");
        checkValue("single_res", int'(res_o), 27);
        checkValue("single_ready", int'(ready_o), 2);
        req_i = 3'b000;
        runCycle("single_done");

        // Subtract underflow and add overflow
        applyStimulus(3'b001, 3'b000, {16'd0, 8'd3}, {16'd0, 8'd5});
        runCycle("sub_wrap");
        checkValue("sub_wrap_res", int'(res_o), 254);
        req_i = 3'b000;
        runCycle("sub_wrap_done");
        applyStimulus(3'b001, 3'b001, {16'd0, 8'hF0}, {16'd0, 8'h20});
        runCycle("add_wrap");
        checkValue("add_wrap_res", int'(res_o), 16);
        req_i = 3'b000;
        runCycle("add_wrap_done");

        // Operand change during the pulse must not disturb the captured result
        applyStimulus(3'b001, 3'b001, {16'd0, 8'd10}, {16'd0, 8'd1});
        runCycle("late_change_grant");
        applyStimulus(3'b000, 3'b000, {16'd0, 8'd99}, {16'd0, 8'd1});
        #1;
        checkValue("late_change_res", int'(res_o), 11);
        runCycle("late_change_done");
        checkValue("late_change_hold", int'(res_o), 11);

        // Reset asserted during the pulse cycle
        applyStimulus(3'b100, 3'b100, {8'd50, 16'd0}, {8'd8, 16'd0});
        runCycle("pre_reset_grant");
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset");
        #1 rst_n = 1'b1;
        runCycle("regrant_after_reset");
        checkValue("regrant_res", int'(res_o), 58);

        // Sixteen back-to-back operations wrap the 4-bit counter
        req_i = 3'b001;
        mode_i = 3'b001;
        runCycle("cnt_first_done");
        for (int i = 0; i < 32; i++) runCycle("cnt_wrap");
        checkValue("cnt_wrapped", int'(ops_cnt_o), 1);
        req_i = 3'b000;
        runCycle("cnt_drain");

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), 3'($urandom), 24'($urandom), 24'($urandom));
            runCycle("random");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
